// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DataMemory two-port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int unsigned PORT_LSU = 0;
  localparam int unsigned PORT_AUX = 1;

  // Number of byte-offset bits in an address for an n-bit memory word.
  function automatic int unsigned byte_off_w(input int unsigned n);
    return $clog2(n / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = '0;
    if (&valid)
      winner = ~last_grant;
    else if (valid[PORT_AUX])
      winner = 1'b1;
    if (|valid) begin
      if (winner) grant[PORT_AUX] = 1'b1;
      else        grant[PORT_LSU] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port DataMemory.
// Optional out-of-range address check enabled by DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N          = 64,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           reqValid,
  output logic [1:0]           reqReady,
  input  logic [1:0]           reqWrite,
  input  logic [2*(N/8)-1:0]   reqMask,
  input  logic [2*N-1:0]       reqAddr,
  input  logic [2*N-1:0]       reqWdata,
  output logic [1:0]           rspValid,
  output logic [N-1:0]         rspData,
`ifdef DMEM_ARB_RANGE_CHECK_EN
  output logic                 rspErr,
`endif
  output logic                 memWriteEnable,
  output logic [N/8-1:0]       memWriteMask,
  output logic [N-1:0]         memAddress,
  output logic [N-1:0]         memWriteData,
  input  logic [N-1:0]         memReadData
);

  localparam int unsigned MW = N / 8;

  state_t         state, state_nxt;
  logic           last_grant;
  logic           owner_q, write_q, err_q;
  logic [MW-1:0]  mask_q;
  logic [N-1:0]   addr_q, wdata_q;
  logic [1:0]     grant;
  logic           winner;
  logic           accept;
  logic [N-1:0]   sel_addr;
  logic           sel_err;

  rr_arbiter2 u_rr (
    .valid      (reqValid),
    .last_grant (last_grant),
    .grant      (grant),
    .winner     (winner)
  );

  assign sel_addr = winner ? reqAddr[2*N-1:N] : reqAddr[N-1:0];

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam int unsigned HI_LSB = byte_off_w(N) + DEPTH_LOG2;
  assign sel_err = |(sel_addr >> HI_LSB);
`else
  assign sel_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Reset masks ready and the memory port combinationally so a store caught
  // in ACCESS while reset is high never reaches the memory.
  always_comb begin
    state_nxt      = state;
    reqReady       = '0;
    accept         = 1'b0;
    memWriteEnable = 1'b0;
    memWriteMask   = '0;
    memAddress     = '0;
    memWriteData   = '0;
    unique case (state)
      IDLE: begin
        if (!reset) reqReady = grant;
        accept = |(reqValid & reqReady);
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = RESPOND;
        if (!reset) begin
          memAddress     = addr_q;
          memWriteData   = wdata_q;
          memWriteEnable = write_q & ~err_q;
          memWriteMask   = err_q ? '0 : mask_q;
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      mask_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rspValid   <= '0;
      rspData    <= '0;
    end else begin
      if (accept) begin
        owner_q    <= winner;
        last_grant <= winner;
        write_q    <= reqWrite[winner];
        err_q      <= sel_err;
        mask_q     <= winner ? reqMask[2*MW-1:MW] : reqMask[MW-1:0];
        addr_q     <= sel_addr;
        wdata_q    <= winner ? reqWdata[2*N-1:N] : reqWdata[N-1:0];
      end
      if (state == ACCESS) begin
        rspValid <= owner_q ? 2'b10 : 2'b01;
        rspData  <= (write_q || err_q) ? '0 : memReadData;
      end else begin
        rspValid <= '0;
      end
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                rspErr <= 1'b0;
    else if (state == ACCESS) rspErr <= err_q;
    else                      rspErr <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory stand-in.
// Range-check expectations follow DMEM_ARB_RANGE_CHECK_EN.
module tb_dmem_arbiter;

  localparam int unsigned N  = 64;
  localparam int unsigned MW = N / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        reqValid, reqReady, reqWrite, rspValid;
  logic [2*MW-1:0]   reqMask;
  logic [2*N-1:0]    reqAddr, reqWdata;
  logic [N-1:0]      rspData, memAddress, memWriteData, memReadData;
  logic [MW-1:0]     memWriteMask;
  logic              memWriteEnable;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic              rspErr;
`endif

  logic [N-1:0] mem [0:1023];
  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  int unsigned  wr_count = 0;
  int unsigned  wr_base;

  dmem_arbiter #(.N(N), .DEPTH_LOG2(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqMask        (reqMask),
    .reqAddr        (reqAddr),
    .reqWdata       (reqWdata),
    .rspValid       (rspValid),
    .rspData        (rspData),
`ifdef DMEM_ARB_RANGE_CHECK_EN
    .rspErr         (rspErr),
`endif
    .memWriteEnable (memWriteEnable),
    .memWriteMask   (memWriteMask),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .memReadData    (memReadData)
  );

  always #5 clk = ~clk;

  // DataMemory stand-in: combinational read, byte-enable write, word index aliases.
  assign memReadData = mem[memAddress[12:3]];
  always @(posedge clk) begin
    if (memWriteEnable) begin
      wr_count++;
      for (int b = 0; b < int'(MW); b++)
        if (memWriteMask[b]) mem[memAddress[12:3]][b*8 +: 8] <= memWriteData[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reqValid = '0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single-port transaction with checks in each of the three FSM cycles.
  task automatic txn(input string tag, input int p, input logic wr, input logic [7:0] m,
                     input logic [63:0] a, input logic [63:0] wd,
                     input logic [63:0] exp_d, input logic exp_err);
    logic exp_we;
    exp_we = wr & ~exp_err;
    @(negedge clk);
    reqValid           = onehot(p);
    reqWrite[p]        = wr;
    reqMask[p*8 +: 8]  = m;
    reqAddr[p*64 +: 64]  = a;
    reqWdata[p*64 +: 64] = wd;
    #1 check({tag, ".ready"}, reqReady, onehot(p));
    @(posedge clk);
    @(negedge clk);
    reqValid             = '0;
    reqAddr[p*64 +: 64]  = ~a;
    reqWdata[p*64 +: 64] = ~wd;
    reqMask[p*8 +: 8]    = ~m;
    #1;
    check({tag, ".acc_ready"}, reqReady, 2'b00);
    check({tag, ".acc_addr"}, memAddress, a);
    check({tag, ".acc_we"}, memWriteEnable, exp_we);
    check({tag, ".acc_mask"}, memWriteMask, exp_err ? 8'h00 : m);
    check({tag, ".acc_wdata"}, memWriteData, wd);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, ".rsp_valid"}, rspValid, onehot(p));
    check({tag, ".rsp_data"}, rspData, exp_d);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    check({tag, ".rsp_err"}, rspErr, exp_err);
`endif
    @(posedge clk);
    #1 check({tag, ".rsp_done"}, rspValid, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 64'h1122_3344_5566_7788;
    mem[6] = 64'hA5A5_A5A5_5A5A_5A5A;
    reset    = 1'b1;
    reqValid = 2'b11;
    reqWrite = '0;
    reqMask  = '0;
    reqAddr  = '0;
    reqWdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("rst.ready", reqReady, 2'b00);
    reqValid = '0;
    reset    = 1'b0;
    #1;
    check("rst.rsp_valid", rspValid, 2'b00);
    check("rst.rsp_data", rspData, 64'h0);
    check("rst.mem_we", memWriteEnable, 1'b0);
    check("rst.mem_addr", memAddress, 64'h0);
    check("rst.mem_mask", memWriteMask, 8'h00);
    check("rst.mem_wdata", memWriteData, 64'h0);

    // Single load, byte store, readback
    txn("load0", 0, 1'b0, 8'hFF, 64'h28, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
    wr_base = wr_count;
    txn("bstore1", 1, 1'b1, 8'h01, 64'h28, 64'hFF, 64'h0, 1'b0);
    check("bstore1.wr_cycles", 64'(wr_count - wr_base), 64'd1);
    txn("rdback0", 0, 1'b0, 8'h00, 64'h28, 64'h0, 64'h1122_3344_5566_77FF, 1'b0);

    // Zero-mask store: access still happens, word unchanged
    wr_base = wr_count;
    txn("zstore", 0, 1'b1, 8'h00, 64'h28, 64'hDEAD, 64'h0, 1'b0);
    check("zstore.wr_cycles", 64'(wr_count - wr_base), 64'd1);
    txn("zrdback", 1, 1'b0, 8'hFF, 64'h28, 64'h0, 64'h1122_3344_5566_77FF, 1'b0);

    // Reset during ACCESS: port 0 store dropped, lastGrant returns to 1
    @(negedge clk);
    reqValid = 2'b01; reqWrite = 2'b01; reqMask = 16'h00FF;
    reqAddr  = {64'h0, 64'h30}; reqWdata = {64'h0, 64'h1234};
    #1 check("midrst.ready", reqReady, 2'b01);
    @(posedge clk);
    @(negedge clk);
    reqValid = '0;
    reset    = 1'b1;
    wr_base  = wr_count;
    #1;
    check("midrst.mem_we", memWriteEnable, 1'b0);
    check("midrst.mem_addr", memAddress, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    reqWrite = '0;
    reqAddr  = {64'h30, 64'h28};
    reqValid = 2'b11;
    #1;
    check("midrst.rsp_valid", rspValid, 2'b00);
    check("midrst.rsp_data", rspData, 64'h0);
    check("midrst.no_write", 64'(wr_count - wr_base), 64'd0);
    check("midrst.mem6", mem[6], 64'hA5A5_A5A5_5A5A_5A5A);
    check("midrst.first_grant", reqReady, 2'b01);
    @(posedge clk);
    @(negedge clk);
    reqValid = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst.rsp_owner", rspValid, 2'b01);
    check("midrst.rsp_data2", rspData, 64'h1122_3344_5566_77FF);
    @(posedge clk);

    // Out-of-range store at 0x2000
`ifdef DMEM_ARB_RANGE_CHECK_EN
    wr_base = wr_count;
    txn("range", 0, 1'b1, 8'hFF, 64'h2000, 64'hCAFE, 64'h0, 1'b1);
    check("range.no_write", 64'(wr_count - wr_base), 64'd0);
    check("range.mem0", mem[0], 64'h0);
    txn("range_ok", 1, 1'b0, 8'hFF, 64'h30, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);
`else
    txn("alias", 0, 1'b1, 8'hFF, 64'h2000, 64'hCAFE, 64'h0, 1'b0);
    check("alias.mem0", mem[0], 64'hCAFE);
`endif

    // Contention: both ports valid for 6 transactions after reset
    do_reset();
    reqWrite = '0;
    reqMask  = 16'hFFFF;
    reqAddr  = {64'h30, 64'h28};
    reqValid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      int p;
      p = t % 2;
      #1 check($sformatf("cont%0d.grant", t), reqReady, onehot(p));
      @(posedge clk);
      @(negedge clk);
      #1 check($sformatf("cont%0d.acc_ready", t), reqReady, 2'b00);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("cont%0d.rsp_valid", t), rspValid, onehot(p));
      check($sformatf("cont%0d.rsp_ready", t), reqReady, 2'b00);
      check($sformatf("cont%0d.rsp_data", t), rspData,
            (p == 0) ? 64'h1122_3344_5566_77FF : 64'hA5A5_A5A5_5A5A_5A5A);
      @(posedge clk);
      @(negedge clk);
    end
    reqValid = '0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
